// File: rtl/rr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// rr_burst_arbiter
//
// Round-robin burst arbiter. It produces the registered one-hot select that
// drives the one-hot AND-OR data mux on the read/write arbiter and read port
// paths. One port is granted at a time. The grant is held until the requested
// number of beats has been acknowledged by the memory pool side. Priority
// then rotates to the port after the one just served.
//
// Parameters:
//   PORT_NUM     number of requesting ports (1, 3 or 4); width of grant
//   LEN_WIDTH    width of each port's burst-length-minus-1 field
//   TIMEOUT_CYC  stall watchdog limit in cycles (ARB_TIMEOUT_EN builds only)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-port request level, bit i = port i
//   req_len      per-port burst length minus 1, port i at [i*LEN_WIDTH +: LEN_WIDTH]
//   beat_ack     one beat of the granted burst consumed this cycle
//   grant        registered one-hot grant (mux select)
//   grant_valid  OR of grant
//   burst_last   pulse in the cycle the final beat_ack of a burst is accepted
//   timeout_err  pulse in the cycle the watchdog releases a stalled burst
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : a stalled burst (no beat_ack for TIMEOUT_CYC cycles) is
//               released and timeout_err pulses.
//   Undefined : no watchdog; timeout_err is tied to 0.
// ---------------------------------------------------------------------------
module rr_burst_arbiter #(
   parameter int PORT_NUM    = 3,
   parameter int LEN_WIDTH   = 8,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PORT_NUM-1:0]           req,
   input  logic [PORT_NUM*LEN_WIDTH-1:0] req_len,
   input  logic                          beat_ack,
   output logic [PORT_NUM-1:0]           grant,
   output logic                          grant_valid,
   output logic                          burst_last,
   output logic                          timeout_err
);

   localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
   localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   // Reject configurations the downstream mux does not support.
   if (PORT_NUM != 1 && PORT_NUM != 3 && PORT_NUM != 4) begin : g_bad_port_num
      $error("rr_burst_arbiter: PORT_NUM must be 1, 3 or 4");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("rr_burst_arbiter: TIMEOUT_CYC must be at least 2");
   end

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     cur;
   logic [LEN_WIDTH-1:0] cnt;
   logic                 win_found;
   logic [PTR_W-1:0]     win_idx;
   logic                 timeout_hit;

   // Pick the next winner. The search starts one past the port served most
   // recently, so that port has the lowest priority. After reset the pointer
   // sits at PORT_NUM-1, which gives port 0 first priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= PORT_NUM; k++) begin
         if (!win_found && req[(int'(ptr) + k) % PORT_NUM]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'((int'(ptr) + k) % PORT_NUM);
         end
      end
   end

   // The final acknowledge of a burst arrives while the remaining-beat
   // counter is already zero. That acknowledge is the one flagged here.
   assign burst_last  = (state == BURST) && beat_ack && (cnt == '0);
   assign grant_valid = |grant;

`ifdef ARB_TIMEOUT_EN
   logic [TO_W-1:0] idle_cnt;

   // The watchdog fires on the TIMEOUT_CYC-th consecutive stalled cycle of a
   // burst. The stall counter restarts on every acknowledge.
   assign timeout_hit = (state == BURST) && !beat_ack &&
                        (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign timeout_err = timeout_hit;

   // Stall counter. It is cleared when a burst starts and on every beat. It
   // counts only the BURST cycles that have no acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (state == IDLE || beat_ack || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Main arbitration FSM.
   // IDLE: grant the winner (if any) and latch its burst length.
   // BURST: count acknowledges down. On the last one (or on a watchdog
   // release), drop the grant and make the served port the new pointer.
   // Going back through IDLE always leaves a one-cycle gap with no grant, so
   // the mux select never has two hot bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         cnt   <= '0;
         cur   <= '0;
         ptr   <= PTR_W'(PORT_NUM - 1);
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant <= PORT_NUM'(1) << win_idx;
                  cnt   <= req_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
                  cur   <= win_idx;
                  state <= BURST;
               end
            end
            BURST: begin
               if (beat_ack) begin
                  if (cnt == '0) begin
                     grant <= '0;
                     ptr   <= cur;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end else if (timeout_hit) begin
                  grant <= '0;
                  ptr   <= cur;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

   // The mux downstream must never see more than one select bit set.
   a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that produces the registered one-hot select vector driving the one-hot AND-OR data mux in the read/write arbiter and read port paths.
- Accepts per-port burst requests and grants exactly one port at a time.
- Holds the grant for the full burst length, counted in beat acknowledges from the memory pool side.
- Rotates priority after each completed burst.

Parameters:
- PORT_NUM, 3, number of requesting ports; width of the one-hot grant. Legal values: 1, 3, 4, matching the mux widths in use.
- LEN_WIDTH, 8, width of each port's burst-length field.
- TIMEOUT_CYC, 256, watchdog limit in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  PORT_NUM  per-port request level; bit i = port i.
- req_len  input  PORT_NUM*LEN_WIDTH  per-port burst length minus 1; port i occupies bits [(i+1)*LEN_WIDTH-1 : i*LEN_WIDTH].
- beat_ack  input  1  one data beat of the granted burst consumed this cycle.
- grant  output  PORT_NUM  registered one-hot grant; feeds the mux ctrl input directly.
- grant_valid  output  1  high when grant is non-zero; equals OR of grant.
- burst_last  output  1  single-cycle pulse on the cycle the final beat_ack of a burst is accepted.
- timeout_err  output  1  single-cycle pulse on watchdog release. Tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset values (async, while rst_n=0):
  - grant=0, grant_valid=0, burst_last=0, timeout_err=0.
  - state=IDLE, beat counter=0.
  - rr pointer = PORT_NUM-1, so port 0 has first priority after reset.
- States: IDLE, BURST.
- IDLE:
  - If req != 0, select the first set req bit searching upward from (pointer+1) mod PORT_NUM, wrapping.
  - On that edge: grant <= one-hot of winner; counter <= winner's req_len; state <= BURST.
  - If req == 0, stay in IDLE with grant=0.
  - beat_ack in IDLE is ignored.
- BURST:
  - Each beat_ack with counter != 0 decrements counter.
  - beat_ack with counter == 0 ends the burst. Combinationally burst_last=1 that cycle. On the edge: grant <= 0, pointer <= winner index, state <= IDLE.
  - Without beat_ack, counter and grant hold.
- Latency:
  - Request to grant: 1 cycle.
  - Minimum 1-cycle bubble (grant=0) between consecutive bursts, even for back-to-back requests. This keeps the downstream mux select free of two hot bits.
- Burst length: req_len=0 means 1 beat; maximum is 2^LEN_WIDTH beats.
- Length is sampled only at grant. Changes to req_len during BURST have no effect.
- Deassertion of the granted port's req mid-burst is ignored; the burst runs to completion.
- Requests from other ports during BURST are held pending and considered at the next IDLE cycle.
- grant is never multi-hot. Assertion: $onehot0(grant) every cycle.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,0,... for PORT_NUM=3.
- PORT_NUM=1: pointer is constant; behaviour reduces to a burst gate.
- Reset asserted mid-burst: immediate return to reset values. The partially completed burst is abandoned; no burst_last is issued.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An idle-beat counter clears on every beat_ack and on entry to BURST.
  - It increments on each BURST cycle without beat_ack.
  - When it reaches TIMEOUT_CYC-1 with no beat_ack: timeout_err pulses for 1 cycle. On the edge, grant <= 0, pointer <= winner, state <= IDLE. No burst_last is issued.
- When undefined: the counter does not exist, timeout_err is constant 0, and a stalled burst holds the grant indefinitely.

Test Plan:
- Reset then req=3'b001, req_len[0]=2, beat_ack high every cycle -> grant=3'b001 one cycle after req; burst_last on the 3rd ack; grant=0 the next cycle.
- req=3'b111 held, all req_len=0, beat_ack=1 -> grant sequence 001,000,010,000,100,000,001; burst_last pulses once per grant.
- Port 1 granted with req_len=3; req[1] dropped after first ack; beat_ack applied with gaps (1,0,0,1,1,1) -> grant holds through 4 acks; burst_last on the 4th ack only.
- req_len[2]=255 on port 2 -> exactly 256 acks before burst_last; counter wraps nowhere; grant stays 3'b100 throughout.
- rst_n pulled low after 2 of 5 beats -> grant=0 asynchronously, no burst_last. After release with req=3'b111, port 0 is granted first.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=16, grant with no beat_ack -> timeout_err pulse on the 16th stalled cycle; grant=0 next cycle; the next winner is the following port in rotation.
